mul_seq: RTL and testbench

//   Sequential unsigned fixed-point multiplier; companion to the sequential divider in rtl/maths.

---
 rtl/mul_seq.sv | 112 +++++++++++
 tb/tb_mul_seq.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/mul_seq.sv
// Sequential unsigned fixed-point multiplier, radix-2 shift-and-add: p = sat((x*y) >> FBITS).
// Latency: WIDTH cycles from the start edge to o_valid. The latency is fixed and never exits early.
// Backpressure: none. i_start restarts at any time and takes priority over a job in flight.
// Results are held until the next i_start or reset.
//
// Ports:
//   i_clk, i_rst_n    clock (rising edge) and async active-low reset
//   i_start           start pulse; i_x/i_y are sampled on this edge
//   i_x, i_y          multiplicand / multiplier, WIDTH bits, FBITS fractional bits
//   o_busy            calculation in progress
//   o_valid           o_p/o_ovf hold a valid result (never together with o_busy)
//   o_ovf             product exceeded WIDTH bits after the shift; o_p is saturated to all ones
//   o_p               product, WIDTH bits, FBITS fractional bits, truncated toward zero
module mul_seq #(
  parameter int WIDTH = 8,
  parameter int FBITS = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_valid,
  output logic             o_ovf,
  input  logic [WIDTH-1:0] i_x,
  input  logic [WIDTH-1:0] i_y,
  output logic [WIDTH-1:0] o_p
);

  localparam int AW = 2 * WIDTH;
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [WIDTH-1:0] x1_q, x1_d;
  logic [WIDTH-1:0] y1_q, y1_d;
  logic [AW-1:0]    acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic [WIDTH-1:0] p_q, p_d;

  logic [AW-1:0]    addend;
  logic [AW-1:0]    acc_nxt;
  logic             hi_nz;

  // Partial product for this cycle's multiplier bit. The accumulator is 2*WIDTH wide, so the
  // sum never wraps.
  always_comb begin
    addend  = y1_q[cnt_q] ? ({{WIDTH{1'b0}}, x1_q} << cnt_q) : '0;
    acc_nxt = acc_q + addend;
    // Any bit above the retained window means the shifted product does not fit in WIDTH bits.
    hi_nz   = |(acc_nxt >> (WIDTH + FBITS));
  end

  always_comb begin
    x1_d    = x1_q;
    y1_d    = y1_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    p_d     = p_q;
    if (i_start) begin
      // o_p deliberately keeps its previous value until the new result lands.
      x1_d    = i_x;
      y1_d    = i_y;
      acc_d   = '0;
      cnt_d   = '0;
      busy_d  = 1'b1;
      valid_d = 1'b0;
      ovf_d   = 1'b0;
    end else if (busy_q) begin
      acc_d = acc_nxt;
      cnt_d = cnt_q + CW'(1);
      if (cnt_q == LAST) begin
        busy_d  = 1'b0;
        valid_d = 1'b1;
        ovf_d   = hi_nz;
        p_d     = hi_nz ? {WIDTH{1'b1}} : acc_nxt[WIDTH+FBITS-1:FBITS];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      x1_q    <= '0;
      y1_q    <= '0;
      acc_q   <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      p_q     <= '0;
    end else begin
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      p_q     <= p_d;
    end
  end

  assign o_busy  = busy_q;
  assign o_valid = valid_q;
  assign o_ovf   = ovf_q;
  assign o_p     = p_q;

endmodule

// File: tb/tb_mul_seq.sv
// Bench for mul_seq: two instances (8-bit Q4.4 and 4-bit integer).
// Directed cases, random pairs, and a full 4-bit sweep are run against an arithmetic model.
// Restart and mid-run reset behaviour are exercised as well.
module tb_mul_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       s8 = 1'b0, b8, v8, o8;
  logic [7:0] x8 = '0, y8 = '0, p8;
  logic       s4 = 1'b0, b4, v4, o4;
  logic [3:0] x4 = '0, y4 = '0, p4;

  int checks = 0;
  int errors = 0;

  mul_seq #(.WIDTH(8), .FBITS(4)) u_m8 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(s8), .o_busy(b8), .o_valid(v8),
    .o_ovf(o8), .i_x(x8), .i_y(y8), .o_p(p8));

  mul_seq #(.WIDTH(4), .FBITS(0)) u_m4 (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(s4), .o_busy(b4), .o_valid(v4),
    .o_ovf(o4), .i_x(x4), .i_y(y4), .o_p(p4));

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: the exact product, shifted right and saturated to the result width.
  task automatic model(input bit w4, input int x, input int y, output longint p, output bit ovf);
    longint prod;
    int w, f;
    w = w4 ? 4 : 8;
    f = w4 ? 0 : 4;
    prod = (longint'(x) * longint'(y)) >>> f;
    ovf = (prod > ((longint'(1) << w) - 1));
    p = ovf ? ((longint'(1) << w) - 1) : prod;
  endtask

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Caller must be positioned at a negedge. Drive the start pulse, then count cycles to o_valid.
  task automatic run(input bit w4, input int x, input int y, input string tag);
    longint pe;
    bit oe;
    int lat;
    int w;
    logic vld, bsy, ovf;
    longint p;
    model(w4, x, y, pe, oe);
    w = w4 ? 4 : 8;
    if (w4) begin s4 = 1'b1; x4 = x[3:0]; y4 = y[3:0]; end
    else    begin s8 = 1'b1; x8 = x[7:0]; y8 = y[7:0]; end
    cyc();
    s4 = 1'b0; s8 = 1'b0;
    // The operands must be captured on the start edge, so scramble the inputs afterwards.
    x4 = 4'($urandom); y4 = 4'($urandom);
    x8 = 8'($urandom); y8 = 8'($urandom);
    bsy = w4 ? b4 : b8;
    chk({tag, "_busy"}, longint'(bsy), 1);
    lat = 0;
    do begin
      cyc();
      lat++;
      vld = w4 ? v4 : v8;
    end while (!vld && lat < 40);
    bsy = w4 ? b4 : b8;
    ovf = w4 ? o4 : o8;
    p   = w4 ? longint'(p4) : longint'(p8);
    chk({tag, "_lat"}, lat, w);
    chk({tag, "_p"}, p, pe);
    chk({tag, "_ovf"}, longint'(ovf), longint'(oe));
    chk({tag, "_busy0"}, longint'(bsy), 0);
  endtask

  initial begin
    int seen;
    int x, y;
    longint keep;

    // Reset state
    #1;
    chk("rst_b8", b8, 0); chk("rst_v8", v8, 0); chk("rst_o8", o8, 0); chk("rst_p8", p8, 0);
    chk("rst_v4", v4, 0); chk("rst_p4", p4, 0);
    @(negedge clk);
    rst_n = 1'b1;
    cyc();

    // Directed cases, 8-bit Q4.4
    run(0, 'h30, 'h28, "t1_3x2p5");
    run(0, 'h80, 'h40, "t2_ovf");
    run(0, 'h10, 'h10, "t2_1x1");
    run(0, 'h01, 'h01, "t3_trunc");
    run(0, 'h00, 'hFF, "t3_zero");
    run(0, 'hFF, 'hFF, "max8");

    // Results hold while idle, even with the inputs changing.
    keep = p8;
    repeat (5) begin x8 = 8'($urandom); cyc(); end
    chk("hold_v", v8, 1);
    chk("hold_p", p8, keep);

    // Directed cases, 4-bit integer
    run(1, 3, 5, "t4_3x5");
    run(1, 15, 15, "t4_15x15");

    // Random 8-bit pairs
    for (int i = 0; i < 40; i++) begin
      x = int'($urandom_range(0, 255));
      y = int'($urandom_range(0, 255));
      run(0, x, y, "rnd8");
    end

    // Full 4-bit sweep
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        run(1, a, b, "sweep4");

    // Restart: a second start at cycle 4 aborts the first job and sets its own latency.
    s8 = 1'b1; x8 = 8'h30; y8 = 8'h20;
    cyc();
    s8 = 1'b0;
    seen = 0;
    repeat (3) begin cyc(); if (v8) seen++; end
    chk("t5_no_valid_before", seen, 0);
    run(0, 'h20, 'h20, "t5_restart");
    chk("t5_p", p8, 'h40);

    // Reset in the middle of a run.
    s8 = 1'b1; x8 = 8'h30; y8 = 8'h20;
    cyc();
    s8 = 1'b0;
    repeat (3) cyc();
    rst_n = 1'b0;
    #1;
    chk("t6_b", b8, 0); chk("t6_v", v8, 0); chk("t6_o", o8, 0); chk("t6_p", p8, 0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (15) begin cyc(); if (v8 || b8) seen++; end
    chk("t6_no_valid_after", seen, 0);
    run(0, 'h30, 'h28, "t6_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Guard against a hung run: the bench must always end on its own.
  initial begin
    #2000000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
